delay_tap_scheduler: RTL and testbench

Runtime-configurable delay line with a controller that owns its tap setting. Wraps a MAX_TAP-deep single-bit DFF chain and exposes the output at the selected tap. It sequences tap changes through a valid/ready config handshake. On each change it flushes in-flight data and flags output validity until the chain has refilled. It sits between a configuration master and any logic that consumes fixed-latency delayed strobes.

---
 rtl/delay_tap_pkg.sv | 17 +
 rtl/delay_shift_chain.sv | 22 ++
 rtl/delay_tap_scheduler.sv | 106 ++++++++++
 tb/tb_delay_tap_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_tap_pkg.sv
// Shared types and helpers for the delay tap scheduler slice.
// The tap width constant is sized so it can hold MAX_TAP itself, not just MAX_TAP-1.
package delay_tap_pkg;

  localparam int MAX_TAP_DEFAULT = 16;
  localparam int TAP_W_DEFAULT   = $clog2(MAX_TAP_DEFAULT + 1);

  typedef enum logic {
    RUN,
    SETTLE
  } state_t;

  function automatic logic tap_legal(input int tap, input int max_tap);
    return (tap >= 1) && (tap <= max_tap);
  endfunction

endpackage

// File: rtl/delay_shift_chain.sv
// Single-bit DFF chain with synchronous clear and shift enable.
// Clear takes priority over shifting, so the input bit is dropped on a clear edge.
module delay_shift_chain #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [DEPTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/delay_tap_scheduler.sv
// Runtime-configurable delay line: owns the tap register, flushes the chain on every
// accepted tap change and holds out_valid low until the chain has refilled.
module delay_tap_scheduler
  import delay_tap_pkg::*;
#(
  parameter int MAX_TAP     = MAX_TAP_DEFAULT,
  parameter int TAP_W       = TAP_W_DEFAULT,
  parameter int DEFAULT_TAP = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [TAP_W-1:0] cfg_tap,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             delayed,
  output logic             out_valid,
  output logic             busy,
  output logic [TAP_W-1:0] cur_tap
);

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [TAP_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               clr;
  logic               tap_bit;
  logic [MAX_TAP-1:0] chain_q;

  // Every handshake in RUN completes; illegal taps only raise a one-cycle error.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_valid) begin
          if (tap_legal(int'(cfg_tap), MAX_TAP)) begin
            tap_d   = cfg_tap;
            cnt_d   = cfg_tap;
            clr     = 1'b1;
            state_d = SETTLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (en) begin
          cnt_d = cnt_q - TAP_W'(1);
          if (cnt_q == TAP_W'(1)) begin
            state_d = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SETTLE;
      tap_q   <= TAP_W'(DEFAULT_TAP);
      cnt_q   <= TAP_W'(DEFAULT_TAP);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  delay_shift_chain #(
    .DEPTH(MAX_TAP)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .din (in),
    .q   (chain_q)
  );

  // Tap select as a compare loop so the index width never depends on MAX_TAP being a power of two.
  always_comb begin
    tap_bit = 1'b0;
    for (int i = 0; i < MAX_TAP; i++) begin
      if (tap_q == TAP_W'(i + 1)) begin
        tap_bit = chain_q[i];
      end
    end
  end

  // out_valid is exactly "in RUN": entering SETTLE drops it, leaving SETTLE raises it.
  assign cfg_ready = (state_q == RUN);
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == SETTLE);
  assign delayed   = out_valid & tap_bit;
  assign cur_tap   = tap_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Self-checking bench for delay_tap_scheduler: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a history-based behavioural model.
module tb_delay_tap_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [4:0] cfg_tap = 5'd0;
  logic       cfg_ready, cfg_err, delayed, out_valid, busy;
  logic [4:0] cur_tap;

  int checks = 0;
  int errors = 0;

  delay_tap_scheduler #(
    .MAX_TAP(16),
    .TAP_W(5),
    .DEFAULT_TAP(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_tap   (cfg_tap),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .delayed   (delayed),
    .out_valid (out_valid),
    .busy      (busy),
    .cur_tap   (cur_tap)
  );

  always #5 clk = ~clk;

  // Model: the bits accepted since the last flush (newest first), the active tap,
  // and how many enabled edges have passed since the flush.
  bit hist[$];
  int m_tap  = 3;
  int m_fill = 0;
  bit m_err  = 1'b0;
  bit m_hs   = 1'b0;
  bit m_init = 1'b0;

  always @(posedge clk) begin
    bit ready;
    bit legal;
    if (rst) begin
      hist   = {};
      m_tap  = 3;
      m_fill = 0;
      m_err  = 1'b0;
      m_hs   = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      ready = (m_fill >= m_tap);
      m_hs  = cfg_valid && ready;
      legal = (int'(cfg_tap) >= 1) && (int'(cfg_tap) <= 16);
      m_err = m_hs && !legal;
      if (m_hs && legal) begin
        m_tap  = int'(cfg_tap);
        hist   = {};
        m_fill = 0;
      end else if (en) begin
        hist.push_front(in);
        if (hist.size() > 16) void'(hist.pop_back());
        if (m_fill < 1000) m_fill++;
      end
    end
  end

  function automatic bit expValid();
    return m_fill >= m_tap;
  endfunction

  function automatic bit expDelayed();
    if (!expValid() || (m_tap - 1) >= hist.size()) return 1'b0;
    return hist[m_tap - 1];
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (m_init) begin
      checkOutput("model.out_valid", 5'(out_valid), 5'(expValid()));
      checkOutput("model.cfg_ready", 5'(cfg_ready), 5'(expValid()));
      checkOutput("model.busy",      5'(busy),      5'(!expValid()));
      checkOutput("model.delayed",   5'(delayed),   5'(expDelayed()));
      checkOutput("model.cfg_err",   5'(cfg_err),   5'(m_err));
      checkOutput("model.cur_tap",   cur_tap,       5'(m_tap));
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic d,
                               input logic v, input logic [4:0] t);
    @(negedge clk);
    rst       = r;
    en        = e;
    in        = d;
    cfg_valid = v;
    cfg_tap   = t;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic       pat[7];
    logic       held;
    logic       pending;
    logic       r_rst;
    logic [4:0] ptap;

    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset.out_valid", 5'(out_valid), 5'd0);
    checkOutput("reset.busy",      5'(busy),      5'd1);
    checkOutput("reset.cfg_ready", 5'(cfg_ready), 5'd0);
    checkOutput("reset.cur_tap",   cur_tap,       5'd3);

    // Refill after reset at the default tap of 3.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("refill.out_valid", 5'(out_valid), 5'(i == 3));
    end
    checkOutput("refill.delayed", 5'(delayed), 5'd1);
    checkOutput("refill.busy",    5'(busy),    5'd0);

    // Pattern 1,0,1,1,0 reappears three edges later.
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 0; pat[6] = 0;
    for (int j = 0; j < 7; j++) begin
      applyStimulus(0, 1, pat[j], 0, 0);
      if (j >= 2) checkOutput("pattern.delayed", 5'(delayed), 5'(pat[j - 2]));
    end

    // Tap 7, with a second request held through SETTLE.
    applyStimulus(0, 1, 1, 1, 5'd7);
    checkOutput("tap7.cur_tap",   cur_tap,        5'd7);
    checkOutput("tap7.cfg_ready", 5'(cfg_ready),  5'd0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1, 5'd4);
      checkOutput("tap7.out_valid", 5'(out_valid), 5'(i == 7));
    end
    checkOutput("tap7.hold_tap", cur_tap, 5'd7);
    applyStimulus(0, 1, 1, 1, 5'd4);
    checkOutput("tap4.cur_tap",   cur_tap,       5'd4);
    checkOutput("tap4.out_valid", 5'(out_valid), 5'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("tap4.refilled", 5'(out_valid), 5'd1);

    // Illegal taps 0, 17 and 31.
    held = delayed;
    applyStimulus(0, 1, held, 1, 5'd0);
    checkOutput("bad0.cfg_err",   5'(cfg_err),   5'd1);
    checkOutput("bad0.cur_tap",   cur_tap,       5'd4);
    checkOutput("bad0.out_valid", 5'(out_valid), 5'd1);
    applyStimulus(0, 1, held, 0, 0);
    checkOutput("bad0.pulse_end", 5'(cfg_err),   5'd0);
    applyStimulus(0, 1, held, 1, 5'd17);
    checkOutput("bad17.cfg_err",  5'(cfg_err),   5'd1);
    checkOutput("bad17.cur_tap",  cur_tap,       5'd4);
    applyStimulus(0, 1, held, 1, 5'd31);
    checkOutput("bad31.cfg_err",  5'(cfg_err),   5'd1);
    applyStimulus(0, 1, held, 0, 0);
    checkOutput("bad31.pulse_end", 5'(cfg_err),  5'd0);

    // Tap 5 with en low for 4 cycles mid-SETTLE: rise moves from edge 5 to edge 9.
    applyStimulus(0, 1, 1, 1, 5'd5);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, (i < 3 || i > 6), 1'($urandom_range(0, 1)), 0, 0);
      checkOutput("stall.out_valid", 5'(out_valid), 5'(i == 9));
    end

    // en low in RUN freezes the output.
    held = delayed;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1'($urandom_range(0, 1)), 0, 0);
      checkOutput("freeze.delayed",   5'(delayed),   5'(held));
      checkOutput("freeze.out_valid", 5'(out_valid), 5'd1);
    end

    // Reset mid-SETTLE with a request pending.
    applyStimulus(0, 1, 1, 1, 5'd9);
    applyStimulus(0, 1, 1, 1, 5'd6);
    applyStimulus(1, 1, 1, 1, 5'd6);
    checkOutput("rst.cur_tap",   cur_tap,       5'd3);
    checkOutput("rst.out_valid", 5'(out_valid), 5'd0);
    checkOutput("rst.cfg_err",   5'(cfg_err),   5'd0);
    checkOutput("rst.delayed",   5'(delayed),   5'd0);
    applyStimulus(0, 1, 1, 1, 5'd6);
    checkOutput("rst.no_accept", cur_tap, 5'd3);
    applyStimulus(0, 1, 0, 0, 0);

    // Randomized traffic with a requester that holds until the handshake.
    pending = 1'b0;
    ptap    = 5'd1;
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      if (!pending && $urandom_range(0, 11) == 0) begin
        pending = 1'b1;
        ptap = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(1, 16));
      end
      applyStimulus(r_rst, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), pending, ptap);
      if (m_hs) pending = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
